// File: rtl/fpsub_seq.sv
// -----------------------------------------------------------------------------
// fpsub_seq
//   Multi-cycle IEEE-754 single-precision subtractor, s = a - b, signed operands.
//   Normals and zero only; round toward zero (bits shifted out are dropped).
//   No NaN, Inf or denormal handling. One operation in flight at a time.
//
//   Build option:
//     FPSUB_BARREL_EN  defined   -> ALIGN and NORM each finish in one cycle
//                                   (barrel shifters + leading-zero count).
//                      undefined -> iterative 1-bit shifters, variable latency.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any operation, clears outputs
//   in_valid   in   operands a, b valid
//   in_ready   out  high only while idle
//   a          in   minuend (IEEE single)
//   b          in   subtrahend (IEEE single)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   s          out  a - b (IEEE single)
//   uflow      out  normalization reached exponent 0, s flushed to +0
//   oflow      out  exponent carried to all-ones, s is the signed Inf pattern
// -----------------------------------------------------------------------------
module fpsub_seq #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned MANT_W    = 23,
    parameter int unsigned MAX_ALIGN = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   a,
    input  logic [EXP_W+MANT_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   s,
    output logic                    uflow,
    output logic                    oflow
);

    localparam int unsigned W     = EXP_W + MANT_W + 1;
    localparam int unsigned MW    = MANT_W + 1;
    localparam int unsigned CNT_W = $clog2(MAX_ALIGN + 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SUB,
        NORM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sign_big_q, sign_big_d;
    logic                sign_sml_q, sign_sml_d;
    logic [MW-1:0]       mant_big_q, mant_big_d;   // also holds the result magnitude after SUB
    logic [MW-1:0]       mant_sml_q, mant_sml_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        s_q, s_d;
    logic                uflow_q, uflow_d;
    logic                oflow_q, oflow_d;

    // ---------------------------------------------------------------- decode
    logic [EXP_W-1:0]    exp_a, exp_b, exp_diff;
    logic [MW-1:0]       mant_a, mant_b;
    logic                a_big;
    logic [CNT_W-1:0]    cnt_load;

    assign exp_a    = a[W-2:MANT_W];
    assign exp_b    = b[W-2:MANT_W];
    assign mant_a   = (exp_a == '0) ? '0 : {1'b1, a[MANT_W-1:0]};
    assign mant_b   = (exp_b == '0) ? '0 : {1'b1, b[MANT_W-1:0]};
    assign a_big    = (exp_a >= exp_b);
    assign exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    assign cnt_load = (exp_diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : CNT_W'(exp_diff);

    // ------------------------------------------------------- add / subtract
    logic [MW:0]         mag_sum;
    logic [MW-1:0]       mag_diff;
    logic                big_ge;
    logic [EXP_W-1:0]    exp_inc;

    assign mag_sum  = {1'b0, mant_big_q} + {1'b0, mant_sml_q};
    assign big_ge   = (mant_big_q >= mant_sml_q);
    assign mag_diff = big_ge ? (mant_big_q - mant_sml_q) : (mant_sml_q - mant_big_q);
    assign exp_inc  = exp_q + EXP_W'(1);

`ifdef FPSUB_BARREL_EN
    // --------------------------------------------- leading-zero count (NORM)
    localparam int unsigned LZ_W = $clog2(MW + 1);
    logic [LZ_W-1:0]     lz;
    logic [MW-1:0]       norm_mant;

    always_comb begin
        lz = LZ_W'(MW);
        // Ascending scan: the highest set bit is the last one to write lz.
        for (int unsigned i = 0; i < MW; i++) begin
            if (mant_big_q[i]) begin
                lz = LZ_W'(MW - 1 - i);
            end
        end
    end

    assign norm_mant = mant_big_q << lz;
`endif

    // ------------------------------------------------------------------ FSM
    logic                fin;
    logic [W-1:0]        fin_s;
    logic                fin_uf;
    logic                fin_of;

    always_comb begin
        state_d     = state_q;
        sign_big_d  = sign_big_q;
        sign_sml_d  = sign_sml_q;
        mant_big_d  = mant_big_q;
        mant_sml_d  = mant_sml_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        uflow_d     = uflow_q;
        oflow_d     = oflow_q;
        fin         = 1'b0;
        fin_s       = '0;
        fin_uf      = 1'b0;
        fin_of      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // b enters with its sign inverted, turning a - b into a + (-b).
                    if (a_big) begin
                        sign_big_d = a[W-1];
                        mant_big_d = mant_a;
                        exp_d      = exp_a;
                        sign_sml_d = ~b[W-1];
                        mant_sml_d = mant_b;
                    end else begin
                        sign_big_d = ~b[W-1];
                        mant_big_d = mant_b;
                        exp_d      = exp_b;
                        sign_sml_d = a[W-1];
                        mant_sml_d = mant_a;
                    end
                    cnt_d   = cnt_load;
                    state_d = ALIGN;
                end
            end

            ALIGN: begin
`ifdef FPSUB_BARREL_EN
                mant_sml_d = mant_sml_q >> cnt_q;
                cnt_d      = '0;
                state_d    = SUB;
`else
                if (cnt_q == '0) begin
                    state_d = SUB;
                end else begin
                    mant_sml_d = mant_sml_q >> 1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end
`endif
            end

            SUB: begin
                if (sign_big_q == sign_sml_q) begin
                    if (mag_sum == '0) begin
                        // Only reachable with two zero operands.
                        fin = 1'b1;
                    end else if (mag_sum[MW]) begin
                        if (exp_inc == '1) begin
                            fin    = 1'b1;
                            fin_of = 1'b1;
                            fin_s  = {sign_big_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        end else begin
                            mant_big_d = mag_sum[MW:1];
                            exp_d      = exp_inc;
                            state_d    = NORM;
                        end
                    end else begin
                        mant_big_d = mag_sum[MW-1:0];
                        state_d    = NORM;
                    end
                end else begin
                    if (mant_big_q == mant_sml_q) begin
                        fin = 1'b1;
                    end else begin
                        mant_big_d = mag_diff;
                        sign_big_d = big_ge ? sign_big_q : sign_sml_q;
                        state_d    = NORM;
                    end
                end
            end

            NORM: begin
`ifdef FPSUB_BARREL_EN
                fin = 1'b1;
                if (EXP_W'(lz) < exp_q) begin
                    fin_s = {sign_big_q, exp_q - EXP_W'(lz), norm_mant[MANT_W-1:0]};
                end else begin
                    fin_uf = 1'b1;
                end
`else
                if (mant_big_q[MW-1]) begin
                    fin   = 1'b1;
                    fin_s = {sign_big_q, exp_q, mant_big_q[MANT_W-1:0]};
                end else if (exp_q == EXP_W'(1)) begin
                    fin    = 1'b1;
                    fin_uf = 1'b1;
                end else begin
                    mant_big_d = mant_big_q << 1;
                    exp_d      = exp_q - EXP_W'(1);
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            s_d         = fin_s;
            uflow_d     = fin_uf;
            oflow_d     = fin_of;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_big_q  <= 1'b0;
            sign_sml_q  <= 1'b0;
            mant_big_q  <= '0;
            mant_sml_q  <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            uflow_q     <= 1'b0;
            oflow_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_big_q  <= sign_big_d;
            sign_sml_q  <= sign_sml_d;
            mant_big_q  <= mant_big_d;
            mant_sml_q  <= mant_sml_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            uflow_q     <= uflow_d;
            oflow_q     <= oflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign uflow     = uflow_q;
    assign oflow     = oflow_q;

endmodule

// File: tb/tb_fpsub_seq.sv
// -----------------------------------------------------------------------------
// tb_fpsub_seq
//   Directed, table-driven bench for fpsub_seq (iterative build): result,
//   flags and accept-to-out_valid latency per vector, plus hand-written
//   back-pressure and mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_fpsub_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        uflow;
    logic        oflow;

    fpsub_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .uflow     (uflow),
        .oflow     (oflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vs;
        logic        vuf;
        logic        vof;
        int unsigned lat;
    } vec_t;

    localparam int unsigned NVEC = 17;
    vec_t vecs [NVEC];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Issues one operation with out_ready high and checks s, flags and latency.
    task automatic run_vec(input int unsigned idx);
        int unsigned lat;
        bit          seen;
        logic [31:0] got_s;
        logic [1:0]  got_f;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = vecs[idx].va;
        b        = vecs[idx].vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        got_s = s;
        got_f = {uflow, oflow};
        check({tag, ".lat"}, 32'(lat), 32'(vecs[idx].lat));
        check({tag, ".s"}, got_s, vecs[idx].vs);
        check({tag, ".flags"}, 32'(got_f), 32'({vecs[idx].vuf, vecs[idx].vof}));
        // out_ready is high, so the next edge completes the handshake.
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned wait_cnt;
        int unsigned hi_cnt;

        //            a             b             s             uf    of    lat
        vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4};   // 3.0 - 1.0
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2};   // equal -> +0
        vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 3};   // carry path
        vecs[3]  = '{32'h3F800000, 32'h3FC00000, 32'hBF000000, 1'b0, 1'b0, 4};   // -0.5, one shift
        vecs[4]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0, 28};  // align saturates
        vecs[5]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 28};  // a zero -> -b
        vecs[6]  = '{32'h40400000, 32'h00000000, 32'h40400000, 1'b0, 1'b0, 28};  // b zero -> a
        vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2};   // +0 - +0
        vecs[8]  = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2};   // -0 - +0 -> +0
        vecs[9]  = '{32'h7F000000, 32'hFF000000, 32'h7F800000, 1'b0, 1'b1, 2};   // +overflow
        vecs[10] = '{32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b0, 1'b1, 2};   // -overflow
        vecs[11] = '{32'h00800001, 32'h00800000, 32'h00000000, 1'b1, 1'b0, 3};   // underflow at exp 1
        vecs[12] = '{32'h01000001, 32'h01000000, 32'h00000000, 1'b1, 1'b0, 4};   // underflow after a shift
        vecs[13] = '{32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 1'b0, 26};  // 23 norm shifts
        vecs[14] = '{32'h3F800000, 32'h3F000001, 32'h3F000000, 1'b0, 1'b0, 5};   // alignment truncation
        vecs[15] = '{32'hBFC00000, 32'h40000000, 32'hC0600000, 1'b0, 1'b0, 4};   // -1.5 - 2.0
        vecs[16] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 4};   // 1.0 - 3.0

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.s", s, 32'h0);
        check("rst.flags", 32'({uflow, oflow}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Back-pressure: result held, busy, and a new request is ignored.
        @(negedge clk);
        out_ready = 1'b0;
        a         = 32'h40400000;
        b         = 32'h3F800000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("bp.lat", 32'(wait_cnt), 32'd4);
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            a        = 32'h3F800000;
            b        = 32'h3FC00000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.s", k), s, 32'h40000000);
            check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release.out_valid", 32'(out_valid), 32'd0);
        check("bp.release.in_ready", 32'(in_ready), 32'd1);
        hi_cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) hi_cnt++;
        end
        check("bp.ignored_req", 32'(hi_cnt), 32'd0);

        // Reset while the long alignment is in progress.
        @(negedge clk);
        a        = 32'h3F800000;
        b        = 32'h30800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.s", s, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        hi_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) hi_cnt++;
        end
        check("midrst.aborted", 32'(hi_cnt), 32'd0);

        run_vec(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
